// File: rtl/mdu_pkg.sv
// mdu_pkg: constants, state type and ALU request helper for the multiply/divide sequencer
package mdu_pkg;
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam int ITER_COUNT = 32;
  typedef enum logic [2:0] {S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE} state_e;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] aluc;
  } alu_req_t;
  // Negate as 0 - x, or pass through as x + 0, so every such step costs one ALU cycle
  function automatic alu_req_t neg_if(input logic [31:0] x, input logic n);
    return n ? alu_req_t'{a: 32'd0, b: x, aluc: ALUC_SUB} : alu_req_t'{a: x, b: 32'd0, aluc: ALUC_ADD};
  endfunction
endpackage

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU controller driving an external 32-bit add/sub ALU
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_s
);
  state_e state_q, state_d;
  logic [4:0] cnt_q;
  logic init_q, sa_q, sb_q, lz_q;
  logic [1:0] op_q;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, hi_q, lo_q;
  logic mul, neg, sgn_in, take, carry;
  logic [31:0] r_sh;
  alu_req_t req;
  assign mul = op_q == OP_MULTU || op_q == OP_MULT;
  assign sgn_in = op == OP_MULT || op == OP_DIV;
  assign neg = sa_q ^ sb_q;
  assign r_sh = {acc_hi_q[30:0], acc_lo_q[31]};
  assign take = acc_hi_q[31] | (r_sh >= opb_q);
  assign carry = acc_lo_q[0] & (alu_s < acc_hi_q);
  assign busy = state_q != S_IDLE && state_q != S_DONE;
  assign done = state_q == S_DONE;
  assign hi = hi_q;
  assign lo = lo_q;
  assign {alu_a, alu_b, alu_aluc} = req;
  always_comb begin
    req = neg_if(32'd0, 1'b0);
    case (state_q)
      S_NEG_A: req = neg_if(opa_q, opa_q[31]);
      S_NEG_B: req = neg_if(opb_q, opb_q[31]);
      S_ITER: if (!init_q) req = mul ? alu_req_t'{a: acc_hi_q, b: acc_lo_q[0] ? opa_q : 32'd0, aluc: ALUC_ADD}
                                     : alu_req_t'{a: r_sh, b: opb_q, aluc: ALUC_SUB};
      S_FIX_LO: req = neg_if(acc_lo_q, neg);
      S_FIX_HI: req = mul ? alu_req_t'{a: neg ? ~acc_hi_q : acc_hi_q, b: {31'd0, neg & lz_q}, aluc: ALUC_ADD}
                          : neg_if(acc_hi_q, sa_q);
      default: ;
    endcase
  end
  // The first ITER cycle loads the accumulators from the (magnitude) operands
  always_comb begin
    state_d = state_q;
    opa_d = opa_q;
    opb_d = opb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = start ? (sgn_in ? S_NEG_A : S_ITER) : S_IDLE;
        opa_d = start ? a : opa_q;
        opb_d = start ? b : opb_q;
      end
      S_NEG_A: begin
        opa_d = alu_s;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        opb_d = alu_s;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (init_q) begin
          acc_hi_d = 32'd0;
          acc_lo_d = mul ? opb_q : opa_q;
        end else if (mul) begin
          acc_hi_d = {carry, alu_s[31:1]};
          acc_lo_d = {alu_s[0], acc_lo_q[31:1]};
        end else begin
          acc_hi_d = take ? alu_s : r_sh;
          acc_lo_d = {acc_lo_q[30:0], take};
        end
        if (!init_q && cnt_q == 5'(ITER_COUNT - 1)) state_d = op_q[0] ? S_FIX_LO : S_DONE;
      end
      S_FIX_LO: begin
        acc_lo_d = alu_s;
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        acc_hi_d = alu_s;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      init_q <= 1'b0;
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      lz_q <= 1'b0;
      opa_q <= '0;
      opb_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q <= (state_q == S_ITER && !init_q) ? cnt_q + 5'd1 : 5'd0;
      init_q <= state_d == S_ITER && state_q != S_ITER;
      if (start && !busy) op_q <= op;
      if (state_q == S_NEG_A) sa_q <= opa_q[31];
      if (state_q == S_NEG_B) sb_q <= opb_q[31];
      if (state_q == S_FIX_LO) lz_q <= acc_lo_q == 32'd0;
      if (state_d == S_DONE) begin
        hi_q <= acc_hi_d;
        lo_q <= acc_lo_d;
      end
    end
  end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide controller for the pipelined CPU's EX stage. Executes MULT, MULTU, DIV and DIVU iteratively, one 32-bit add or subtract per cycle. Arithmetic goes through a dedicated 32-bit ALU instance: this block drives that ALU's operands and `aluc` and consumes its result `s`. HI/LO results are held until the next operation is accepted.

## Interface
Parameters: none (width fixed at 32).
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request; sampled only in IDLE or DONE
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `a`, `b`  in  32  multiplicand/multiplier or dividend/divisor; captured on the accepted `start`
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle on
- `hi`, `lo`  out  32  product high/low word, or remainder/quotient
- `alu_a`, `alu_b`  out  32  ALU operands
- `alu_aluc`  out  4  ALU control: only 4'b0000 (ADD) or 4'b0100 (SUB) is ever driven
- `alu_s`  in  32  ALU result, combinational, same cycle

## Operation
- **States:** IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- **Accepting a request:**
  - Accepted `start` with signed op → NEG_A.
  - Accepted `start` with unsigned op → ITER.
  - `start` during `busy` is ignored.
- **NEG_A / NEG_B (signed ops only):**
  - Replace the operand with its magnitude: SUB 0 − x if negative, else ADD x + 0.
  - Always one cycle each, so latency is fixed.
  - Record both sign bits.
- **ITER (32 cycles, 5-bit counter):**
  - Multiply (shift-add):
    - If multiplier LSB is 1: `alu_s` = hi_acc + mcand via ADD, carry = (`alu_s` <u hi_acc); otherwise carry = 0 and hi_acc is unchanged.
    - {carry, hi_acc, lo_acc} is then shifted right 1.
  - Divide (restoring):
    - {r, q} is shifted left 1; the bit shifted out of r is `r_out`.
    - Trial: `alu_s` = r_shift − divisor via SUB.
    - If `r_out` | !(r_shift <u divisor): r ← `alu_s` and q bit 0 ← 1; otherwise q bit 0 ← 0.
  - Comparisons and shifts are local; the ALU performs only add/sub.
- **FIX_LO / FIX_HI (signed ops only):**
  - MULT, signs differ: negate the 64-bit result. FIX_LO: lo ← 0 − lo (SUB). FIX_HI: hi ← ~hi + (lo_orig == 0) (ADD).
  - DIV: FIX_LO negates the quotient if signs differ. FIX_HI negates the remainder if the dividend was negative.
  - When no fix is needed, pass through with ADD x + 0.
- **DONE:**
  - `done` = 1 for this one cycle; `hi`/`lo` are updated.
  - Next state: start ? (NEG_A | ITER) : IDLE.
- **Divide by zero:** no special case. The algorithm's natural result stands; DIVU x/0 gives lo = 32'hFFFFFFFF, hi = x.
- **Overflow:** DIV 0x80000000 / −1 gives lo = 0x80000000, hi = 0.

## Timing
- Accepted `start` at edge k; `done` is high in the cycle after edge k+33 (unsigned) or edge k+37 (signed).
- `busy` rises the cycle after acceptance and is low during DONE.
- Back-to-back: `start` in the DONE cycle is accepted; no idle bubble.
- `hi`/`lo` change only on the transition into DONE and hold otherwise. Internal accumulators are not visible.
- **Reset:**
  - State → IDLE, counter → 0.
  - `busy`, `done` = 0; `hi`, `lo` = 0.
  - `alu_a`, `alu_b` = 0, `alu_aluc` = 4'b0000.
  - Reset mid-operation abandons the operation; no `done` is produced.
- **ALU outputs in IDLE/DONE:** `alu_a` = `alu_b` = 0, `alu_aluc` = ADD.

## Structure
- **Shared package `mdu_pkg`:**
  - `ALUC_ADD` = 4'b0000, `ALUC_SUB` = 4'b0100.
  - Op codes `OP_MULTU`/`OP_MULT`/`OP_DIVU`/`OP_DIV`.
  - State enum.
  - `ITER_COUNT` = 32.
- **Sub-modules:** none inside this block. The ALU is instantiated in the parent beside this block and wired to the `alu_*` ports.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001, `done` at k+33.
- MULT −3 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, `done` at k+37.
- DIVU 100 / 7 → lo = 14, hi = 2. DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5.
- `start` pulsed while busy is ignored. `start` in the DONE cycle begins the next op, and its `done` arrives exactly 33 or 37 cycles later.
- `reset` at ITER cycle 10 → next cycle IDLE, `hi` = `lo` = 0, no `done`. A fresh MULTU 6 × 7 then yields lo = 42.
